axis_fifo_receiver: RTL

- Downstream AXI4-Stream sink: consumes `axi4s_if.slave` traffic (typically from the FIFO-fed stream sender) and writes beats into a write-side FIFO.
- Provides a 2-entry skid buffer so `tready` is registered, and frames the stream into blocks.
- Blocks close on `tlast` or after `BLOCK_BEATS` beats, since upstream may hold `tlast` low.
- Reports packet count and sticky protocol errors for the control plane.

---
 rtl/axis_fifo_receiver_if.sv | 21 ++
 rtl/axis_fifo_receiver.sv | 103 ++++++++++
 2 files changed

// File: rtl/axis_fifo_receiver_if.sv
// AXI4-Stream bundle shared by the stream sender and receiver.
// The slave modport drives only tready.
interface axi4s_if #(
   parameter int DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic                    tvalid;
   logic                    tready;

   modport master (
      output tdata, tkeep, tlast, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tlast, tvalid,
      output tready
   );
endinterface

// File: rtl/axis_fifo_receiver.sv
// AXI4-Stream sink: 2-entry skid buffer feeding a write-side FIFO,
// with block framing on tlast or a fixed beat count.
module axis_fifo_receiver #(
   parameter int DATA_WIDTH  = 64,
   parameter int BLOCK_BEATS = 256,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   axi4s_if.slave                axis,
   output logic [DATA_WIDTH-1:0] fifo_wr_data,
   output logic                  fifo_wr_last,
   output logic                  fifo_wr_en,
   input  logic                  fifo_full,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic                  block_done,
   output logic                  err_keep,
   input  logic                  clr_err
);

   localparam int BW = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
   localparam logic [BW-1:0] LAST_IDX =
      BW'((BLOCK_BEATS > 0) ? BLOCK_BEATS - 1 : 0);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } beat_t;

   beat_t          out_q;
   beat_t          skid_q;
   beat_t          in_beat;
   logic           out_v;
   logic           skid_v;
   logic           tready_q;
   logic [BW-1:0]  beat_cnt;
   logic           accept;
   logic           drain;
   logic           mark;
   logic           keep_bad;
   logic           wr_last_beat;

   assign axis.tready  = tready_q;
   assign accept       = axis.tvalid && tready_q;
   assign fifo_wr_en   = out_v && !fifo_full;
   assign fifo_wr_data = out_q.data;
   assign fifo_wr_last = out_q.last;
   assign drain        = !out_v || fifo_wr_en;
   assign wr_last_beat = fifo_wr_en && out_q.last;

   // Forced framing only when a block size is configured.
   assign mark = axis.tlast ||
                 ((BLOCK_BEATS != 0) && (beat_cnt == LAST_IDX));
   assign keep_bad = !axis.tlast && (axis.tkeep != '1);
   assign in_beat  = '{data: axis.tdata, last: mark};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_v      <= 1'b0;
         skid_v     <= 1'b0;
         tready_q   <= 1'b0;
         beat_cnt   <= '0;
         pkt_cnt    <= '0;
         block_done <= 1'b0;
         err_keep   <= 1'b0;
      end else begin
         // SKID has priority into OUT; tready only accepts when SKID is empty.
         if (drain) begin
            if (skid_v) begin
               out_q  <= skid_q;
               out_v  <= 1'b1;
               skid_v <= 1'b0;
            end else if (accept) begin
               out_q <= in_beat;
               out_v <= 1'b1;
            end else begin
               out_v <= 1'b0;
            end
            tready_q <= 1'b1;
         end else if (accept) begin
            skid_q   <= in_beat;
            skid_v   <= 1'b1;
            tready_q <= 1'b0;
         end else begin
            tready_q <= !skid_v;
         end

         if (accept) begin
            beat_cnt <= mark ? '0 : beat_cnt + BW'(1);
         end

         block_done <= wr_last_beat;
         if (wr_last_beat) begin
            pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
         end

         err_keep <= (accept && keep_bad) || (err_keep && !clr_err);
      end
   end

endmodule
